// File: rtl/program_memory_pkg.sv
// rtl/program_memory_pkg.sv - shared types and defaults for the loadable program memory
package program_memory_pkg;

  localparam int PM_DATA_WIDTH = 16;
  localparam int PM_ADDR_WIDTH = 8;
  // Wide all-ones source; users truncate it to their own word width.
  localparam logic [63:0] PM_FILL_WORD = '1;

  typedef enum logic [1:0] {
    PM_CLEAR = 2'd0,
    PM_IDLE  = 2'd1,
    PM_LOAD  = 2'd2
  } pm_state_t;

endpackage

// File: rtl/program_memory_loadable_if.sv
// rtl/program_memory_loadable_if.sv - fetch and load port bundle for program_memory_loadable
interface program_memory_loadable_if #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 8
);

  logic                  fetch_req;
  logic [ADDR_WIDTH-1:0] fetch_addr;
  logic                  fetch_ready;
  logic                  fetch_valid;
  logic [DATA_WIDTH-1:0] fetch_instr;
  logic                  load_start;
  logic                  load_clear;
  logic                  load_valid;
  logic [DATA_WIDTH-1:0] load_data;
  logic                  load_last;
  logic                  load_ready;
  logic                  load_done;
  logic [ADDR_WIDTH:0]   load_count;
  logic                  busy;

  modport master (
    output fetch_req, fetch_addr, load_start, load_clear, load_valid, load_data, load_last,
    input  fetch_ready, fetch_valid, fetch_instr, load_ready, load_done, load_count, busy
  );

  modport slave (
    input  fetch_req, fetch_addr, load_start, load_clear, load_valid, load_data, load_last,
    output fetch_ready, fetch_valid, fetch_instr, load_ready, load_done, load_count, busy
  );

endinterface

// File: rtl/pm_storage.sv
// rtl/pm_storage.sv - single-port synchronous RAM with a registered, holding read port
module pm_storage #(
  parameter int                    DATA_WIDTH = 16,
  parameter int                    ADDR_WIDTH = 8,
  parameter logic [DATA_WIDTH-1:0] FILL_WORD  = '1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic                  we,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  re,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [0:(1<<ADDR_WIDTH)-1];
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;

  // The array itself is not reset; the clear sequencer initialises it.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
  end

  always_comb begin
    rdata_d = rdata_q;
    if (re) begin
      rdata_d = mem[addr];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_q <= FILL_WORD;
    end else begin
      rdata_q <= rdata_d;
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/program_memory_loadable.sv
// rtl/program_memory_loadable.sv - writable program memory with clear sequencer and streaming load port
module program_memory_loadable
  import program_memory_pkg::*;
#(
  parameter int                    DATA_WIDTH = PM_DATA_WIDTH,
  parameter int                    ADDR_WIDTH = PM_ADDR_WIDTH,
  parameter logic [DATA_WIDTH-1:0] FILL_WORD  = DATA_WIDTH'(PM_FILL_WORD)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  program_memory_loadable_if.slave  bus
);

  pm_state_t             state_q, state_d;
  logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
  logic                  reload_q, reload_d;
  logic [ADDR_WIDTH:0]   load_count_q, load_count_d;
  logic                  fetch_valid_q, fetch_valid_d;
  logic                  load_done_q, load_done_d;

  logic                  mem_we;
  logic                  mem_re;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic                  cnt_last;

  assign cnt_last = (cnt_q == {ADDR_WIDTH{1'b1}});

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    reload_d      = reload_q;
    load_count_d  = load_count_q;
    fetch_valid_d = 1'b0;
    load_done_d   = 1'b0;
    mem_we        = 1'b0;
    mem_re        = 1'b0;
    mem_addr      = cnt_q;
    mem_wdata     = FILL_WORD;

    case (state_q)
      PM_CLEAR: begin
        mem_we = 1'b1;
        if (cnt_last) begin
          cnt_d    = '0;
          reload_d = 1'b0;
          if (reload_q) begin
            state_d      = PM_LOAD;
            load_count_d = '0;
          end else begin
            state_d = PM_IDLE;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      PM_IDLE: begin
        mem_addr = bus.fetch_addr;
        if (bus.fetch_req) begin
          mem_re        = 1'b1;
          fetch_valid_d = 1'b1;
        end
        if (bus.load_start) begin
          cnt_d = '0;
          if (bus.load_clear) begin
            state_d  = PM_CLEAR;
            reload_d = 1'b1;
          end else begin
            state_d      = PM_LOAD;
            load_count_d = '0;
          end
        end
      end

      PM_LOAD: begin
        mem_wdata = bus.load_data;
        if (bus.load_valid) begin
          mem_we       = 1'b1;
          load_count_d = load_count_q + 1'b1;
          // The top address ends the session so the counter never wraps.
          if (bus.load_last || cnt_last) begin
            state_d     = PM_IDLE;
            load_done_d = 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end

      default: begin
        state_d = PM_CLEAR;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= PM_CLEAR;
      cnt_q         <= '0;
      reload_q      <= 1'b0;
      load_count_q  <= '0;
      fetch_valid_q <= 1'b0;
      load_done_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      reload_q      <= reload_d;
      load_count_q  <= load_count_d;
      fetch_valid_q <= fetch_valid_d;
      load_done_q   <= load_done_d;
    end
  end

  pm_storage #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH),
    .FILL_WORD  (FILL_WORD)
  ) u_storage (
    .clk   (clk),
    .rst_n (rst_n),
    .addr  (mem_addr),
    .we    (mem_we),
    .wdata (mem_wdata),
    .re    (mem_re),
    .rdata (bus.fetch_instr)
  );

  assign bus.fetch_ready = (state_q == PM_IDLE);
  assign bus.load_ready  = (state_q == PM_LOAD);
  assign bus.busy        = (state_q != PM_IDLE);
  assign bus.fetch_valid = fetch_valid_q;
  assign bus.load_done   = load_done_q;
  assign bus.load_count  = load_count_q;

endmodule

// File: tb/tb_program_memory_loadable.sv
// tb/tb_program_memory_loadable.sv - directed and randomized checks of program_memory_loadable
module tb_program_memory_loadable;

  localparam int DW    = 16;
  localparam int AW    = 4;
  localparam int DEPTH = 16;
  localparam logic [DW-1:0] FILL = 16'hFFFF;

  logic clk;
  logic rst_n;
  int   errors;
  int   checks;

  logic [DW-1:0] model [0:DEPTH-1];
  logic [DW-1:0] src   [0:31];

  program_memory_loadable_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  program_memory_loadable #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_fill();
    for (int a = 0; a < DEPTH; a++) model[a] = FILL;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"},        32'(bus.busy), 32'(1));
    check({tag, "_fetch_ready"}, 32'(bus.fetch_ready), 32'(0));
    check({tag, "_fetch_valid"}, 32'(bus.fetch_valid), 32'(0));
    check({tag, "_fetch_instr"}, 32'(bus.fetch_instr), 32'(FILL));
    check({tag, "_load_ready"},  32'(bus.load_ready), 32'(0));
    check({tag, "_load_done"},   32'(bus.load_done), 32'(0));
    check({tag, "_load_count"},  32'(bus.load_count), 32'(0));
  endtask

  // Expects the clear that follows reset release: DEPTH busy cycles, then idle.
  task automatic expect_post_reset_clear(input string tag);
    for (int c = 0; c < DEPTH; c++) begin
      check({tag, "_clr_busy"},  32'(bus.busy), 32'(1));
      check({tag, "_clr_fready"}, 32'(bus.fetch_ready), 32'(0));
      tick();
    end
    check({tag, "_idle_fready"}, 32'(bus.fetch_ready), 32'(1));
    check({tag, "_idle_busy"},   32'(bus.busy), 32'(0));
    model_fill();
  endtask

  task automatic do_fetch(input string tag, input int addr);
    bus.fetch_req  = 1'b1;
    bus.fetch_addr = 4'(addr);
    check({tag, "_ready"}, 32'(bus.fetch_ready), 32'(1));
    tick();
    bus.fetch_req = 1'b0;
    check({tag, "_valid"}, 32'(bus.fetch_valid), 32'(1));
    check({tag, "_instr"}, 32'(bus.fetch_instr), 32'(model[addr]));
    tick();
    check({tag, "_valid_drop"}, 32'(bus.fetch_valid), 32'(0));
  endtask

  task automatic verify_all(input string tag);
    for (int a = 0; a < DEPTH; a++) do_fetch(tag, a);
  endtask

  // Runs one load session from IDLE using src[0..n-1]; a fetch is issued alongside load_start.
  task automatic load_session(input string tag, input bit clr, input int n,
                              input int last_at, input int stall_at);
    int            exp_cnt;
    bit            ended;
    int            fa;
    logic [DW-1:0] pre;
    fa  = int'($urandom_range(0, DEPTH-1));
    pre = model[fa];
    bus.load_start = 1'b1;
    bus.load_clear = clr;
    bus.fetch_req  = 1'b1;
    bus.fetch_addr = 4'(fa);
    check({tag, "_start_fready"}, 32'(bus.fetch_ready), 32'(1));
    tick();
    bus.load_start = 1'b0;
    bus.load_clear = 1'b0;
    bus.fetch_req  = 1'b0;
    check({tag, "_start_fvalid"}, 32'(bus.fetch_valid), 32'(1));
    check({tag, "_start_finstr"}, 32'(bus.fetch_instr), 32'(pre));
    if (clr) begin
      model_fill();
      for (int c = 0; c < DEPTH; c++) begin
        check({tag, "_clr_busy"},  32'(bus.busy), 32'(1));
        check({tag, "_clr_lready"}, 32'(bus.load_ready), 32'(0));
        tick();
      end
    end
    check({tag, "_entry_lready"}, 32'(bus.load_ready), 32'(1));
    check({tag, "_entry_count"},  32'(bus.load_count), 32'(0));
    exp_cnt = 0;
    ended   = 1'b0;
    for (int i = 0; i < n; i++) begin
      if (i == stall_at && !ended) begin
        bus.load_valid = 1'b0;
        for (int k = 0; k < 5; k++) begin
          bus.fetch_req  = 1'b1;
          bus.fetch_addr = 4'($urandom_range(0, DEPTH-1));
          check({tag, "_stall_fready"}, 32'(bus.fetch_ready), 32'(0));
          tick();
          check({tag, "_stall_fvalid"}, 32'(bus.fetch_valid), 32'(0));
          check({tag, "_stall_count"},  32'(bus.load_count), 32'(exp_cnt));
        end
        bus.fetch_req = 1'b0;
      end
      bus.load_valid = 1'b1;
      bus.load_data  = src[i];
      bus.load_last  = (i == last_at);
      check({tag, "_lready"}, 32'(bus.load_ready), ended ? 32'(0) : 32'(1));
      tick();
      if (!ended) begin
        model[exp_cnt] = src[i];
        exp_cnt++;
        if (i == last_at || exp_cnt == DEPTH) begin
          ended = 1'b1;
          check({tag, "_done"},       32'(bus.load_done), 32'(1));
          check({tag, "_done_busy"},  32'(bus.busy), 32'(0));
          check({tag, "_done_ready"}, 32'(bus.load_ready), 32'(0));
          check({tag, "_done_count"}, 32'(bus.load_count), 32'(exp_cnt));
        end else begin
          check({tag, "_no_done"}, 32'(bus.load_done), 32'(0));
        end
      end
    end
    bus.load_valid = 1'b0;
    bus.load_last  = 1'b0;
    tick();
    check({tag, "_done_pulse_end"}, 32'(bus.load_done), 32'(0));
    check({tag, "_count_hold"},     32'(bus.load_count), 32'(exp_cnt));
    check({tag, "_idle_busy"},      32'(bus.busy), 32'(0));
  endtask

  initial begin
    errors = 0;
    checks = 0;
    rst_n          = 1'b0;
    bus.fetch_req  = 1'b0;
    bus.fetch_addr = '0;
    bus.load_start = 1'b0;
    bus.load_clear = 1'b0;
    bus.load_valid = 1'b0;
    bus.load_data  = '0;
    bus.load_last  = 1'b0;
    model_fill();

    // Reset and post-reset clear.
    repeat (2) tick();
    check_reset_outputs("rst");
    rst_n = 1'b1;
    expect_post_reset_clear("boot");
    do_fetch("boot_f0", 0);
    do_fetch("boot_f15", 15);

    // Two-word program terminated by load_last.
    src[0] = 16'b10100_010_00000011;
    src[1] = 16'b10100_011_00000101;
    load_session("two", 1'b0, 2, 1, -1);
    verify_all("two_rd");

    // Over-long stream is truncated at the top address.
    for (int i = 0; i < 20; i++) src[i] = 16'($urandom);
    load_session("long", 1'b0, 20, -1, -1);
    verify_all("long_rd");

    // Clear-then-load erases the previous program.
    src[0] = 16'h1234;
    load_session("clr", 1'b1, 1, 0, -1);
    verify_all("clr_rd");

    // Stalled session with fetch requests during LOAD.
    for (int i = 0; i < 8; i++) src[i] = 16'($urandom);
    load_session("stall", 1'b0, 8, 7, 3);
    verify_all("stall_rd");

    // Randomized sessions.
    for (int s = 0; s < 3; s++) begin
      int n;
      n = int'($urandom_range(1, 12));
      for (int i = 0; i < n; i++) src[i] = 16'($urandom);
      load_session("rnd", 1'($urandom_range(0, 1)), n, n - 1, int'($urandom_range(0, 15)));
      verify_all("rnd_rd");
    end

    // Reset asserted after the third accepted word of a session.
    bus.load_start = 1'b1;
    tick();
    bus.load_start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bus.load_valid = 1'b1;
      bus.load_data  = 16'($urandom);
      check("mid_lready", 32'(bus.load_ready), 32'(1));
      tick();
    end
    bus.load_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("mid_rst");
    tick();
    rst_n = 1'b1;
    expect_post_reset_clear("mid");
    verify_all("mid_rd");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
